// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
//   Upstream control stage for a single parallel MAC unit. Accepts a
//   dot-product command (length K, optional accumulator seed), pulls K
//   activation/weight pairs over a valid/ready stream and drives the MAC
//   inputs from registers. Signals completion once the MAC accumulator
//   holds sum(act*w) + seed.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (accepted only in IDLE)
//   cmd_len                    number of MAC beats K (0 allowed)
//   cmd_seed_en, cmd_seed      accumulator seed select / value
//   in_valid/in_ready          operand pair handshake
//   in_act, in_w               signed operands, passed through bit-exact
//   mac_en, mac_load_accum     registered MAC controls
//   mac_act, mac_w             registered operands to the MAC
//   mac_accum_prev             seed, held for the whole command
//   done_valid/done_ready      result-final handshake
//   busy                       state is not IDLE
module mac_operand_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = DATA_WIDTH + 16,
   parameter int LEN_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  cmd_seed_en,
   input  logic [ACC_WIDTH-1:0]  cmd_seed,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_act,
   input  logic [DATA_WIDTH-1:0] in_w,
   output logic                  mac_en,
   output logic                  mac_load_accum,
   output logic [DATA_WIDTH-1:0] mac_act,
   output logic [DATA_WIDTH-1:0] mac_w,
   output logic [ACC_WIDTH-1:0]  mac_accum_prev,
   output logic                  done_valid,
   input  logic                  done_ready,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t               state, state_next;
   logic [LEN_WIDTH-1:0] len;
   logic [LEN_WIDTH-1:0] count;
   logic                 first;
   logic                 cmd_take;
   logic                 beat;
   logic                 last_beat;

   assign cmd_ready = (state == IDLE);
   assign in_ready  = (state == RUN);
   assign cmd_take  = cmd_valid && cmd_ready;
   assign beat      = in_valid && in_ready;
   // len is nonzero whenever RUN is entered, so len-1 never wraps; the
   // counter tops out at len-1 and cannot overflow even for K = 2^LEN_WIDTH-1.
   assign last_beat = beat && (count == (len - LEN_WIDTH'(1)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (cmd_take) begin
               state_next = (cmd_len == '0) ? DRAIN : RUN;
            end
         end
         RUN: begin
            if (last_beat) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            state_next = DONE;
         end
         DONE: begin
            if (done_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len            <= '0;
         count          <= '0;
         first          <= 1'b0;
         mac_en         <= 1'b0;
         mac_load_accum <= 1'b0;
         mac_act        <= '0;
         mac_w          <= '0;
         mac_accum_prev <= '0;
         done_valid     <= 1'b0;
         busy           <= 1'b0;
      end else begin
         // Controls are single-cycle pulses; bubbles leave operands held
         // but never enable the MAC.
         mac_en         <= 1'b0;
         mac_load_accum <= 1'b0;
         busy           <= (state_next != IDLE);

         if (cmd_take) begin
            len            <= cmd_len;
            count          <= '0;
            first          <= 1'b1;
            mac_accum_prev <= cmd_seed_en ? cmd_seed : '0;
            if (cmd_len == '0) begin
               // Empty dot product: one load beat with zero operands leaves
               // the accumulator equal to the seed.
               mac_en         <= 1'b1;
               mac_load_accum <= 1'b1;
               mac_act        <= '0;
               mac_w          <= '0;
            end
         end

         if (beat) begin
            mac_act        <= in_act;
            mac_w          <= in_w;
            mac_en         <= 1'b1;
            mac_load_accum <= first;
            first          <= 1'b0;
            count          <= count + LEN_WIDTH'(1);
         end

         if (state == DRAIN) begin
            done_valid <= 1'b1;
         end else if ((state == DONE) && done_ready) begin
            done_valid <= 1'b0;
         end
      end
   end

endmodule
